// File: rtl/uart_pkg.sv
// Shared definitions for the UART subsystem (transmitter and receiver).
// The optional even-parity bit of the transmitter is enabled by defining
// the UART_TX_PARITY_EN macro; the PARITY state below is only reached then.
package uart_pkg;

    // Transmitter frame states. PARITY is unused unless parity is enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_BAUD      = 9600;
    localparam int DEFAULT_SYS_CLK   = 12000000;
    localparam int MIN_DATA_BITS     = 5;
    localparam int MAX_DATA_BITS     = 9;

    // A bit period shorter than two clocks leaves no room for a mid-bit
    // sample point on the receive side, so it is rejected at elaboration.
    localparam int MIN_CLKS_PER_BIT  = 2;

    // System clocks per line bit, truncated. Both directions of the UART
    // must agree on this value, so it lives here rather than in a module.
    function automatic int calc_clks_per_bit(input int sys_clk, input int baud);
        return sys_clk / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter. While running it emits a
// one-cycle tick every CLKS_PER_BIT clocks; clearing it restarts the period
// so the first tick of a frame lands exactly one bit time after the start.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_period
            $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    // The tick marks the last clock of the current bit period.
    assign tick = run && (cnt == LAST_COUNT);

    // Period counter: held at zero when stopped or cleared, wraps on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (XOR of the data
// bits) between the last data bit and the stop bit.
//
// Request handshake: ready is high exactly when enable is high and the
// transmitter is idle. A rising edge with ready && new_data accepts the
// request and captures tx_input; tx_input is not looked at otherwise.
// A producer that keeps new_data high through the stop bit gets its next
// word accepted on the first idle cycle.
//
// The line is driven from a register one clock behind the state, so the
// start bit falls on the edge after acceptance. When frames are chained the
// stop bit therefore lasts one clock longer than a bit period.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int BAUD      = DEFAULT_BAUD,
    parameter int SYS_CLK   = DEFAULT_SYS_CLK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] tx_input,
    input  logic                 new_data,
    output logic                 tx_wire,
    output logic                 ready
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(SYS_CLK, BAUD);
    localparam int BIT_CNT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_baud
            $error("uart_tx: SYS_CLK / BAUD must be at least 2");
        end
        if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_width
            $error("uart_tx: DATA_BITS must be in 5..9");
        end
    endgenerate

    uart_tx_state_t         state;
    uart_tx_state_t         state_next;
    logic                   line_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   accept;
    logic                   baud_tick;
    logic                   baud_run;
    logic                   baud_clear;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    assign ready  = enable && (state == IDLE);
    assign accept = ready && new_data;

    // The bit timer runs for the whole frame and restarts on every accepted
    // request, so bit boundaries are always measured from the start bit.
    assign baud_run   = (state != IDLE);
    assign baud_clear = accept || !enable;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .run   (baud_run),
        .tick  (baud_tick)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next line level; enable low overrides everything.
    always_comb begin
        state_next = state;
        line_next  = 1'b1;
        case (state)
            IDLE: begin
                line_next = 1'b1;
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                line_next = 1'b0;
                if (baud_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                line_next = shift_reg[0];
                if (baud_tick && (bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_next = parity_bit;
                if (baud_tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                line_next = 1'b1;
                if (baud_tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                line_next  = 1'b1;
            end
        endcase
        if (!enable) begin
            state_next = IDLE;
            line_next  = 1'b1;
        end
    end

    // Registered serial line; reset drives it high without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wire <= 1'b1;
        end else begin
            tx_wire <= line_next;
        end
    end

    // Data path: capture on acceptance, shift one bit out per data-bit tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            shift_reg <= tx_input;
            bit_cnt   <= '0;
        end else if (!enable) begin
            bit_cnt   <= '0;
        end else if ((state == DATA) && baud_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the captured word, frozen for the rest of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^tx_input;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a 16-clock bit period (16 MHz / 1 Mbaud).
// Follows UART_TX_PARITY_EN so the same bench covers both builds.
module tb_uart_tx;

    localparam int C = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    // Line bits, index 0 = start bit, then data LSB first, parity, stop.
    localparam logic [10:0] EXP_00 = 11'b1_0_00000000_0;
    localparam logic [10:0] EXP_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] EXP_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] EXP_81 = 11'b1_0_10000001_0;
    localparam logic [10:0] EXP_BE = 11'b1_0_10111110_0;
    localparam logic [10:0] EXP_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] EXP_55 = 11'b1_0_01010101_0;
`else
    localparam int NB = 10;
    localparam logic [10:0] EXP_00 = 11'b0_1_00000000_0;
    localparam logic [10:0] EXP_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] EXP_07 = 11'b0_1_00000111_0;
    localparam logic [10:0] EXP_81 = 11'b0_1_10000001_0;
    localparam logic [10:0] EXP_BE = 11'b0_1_10111110_0;
    localparam logic [10:0] EXP_3C = 11'b0_1_00111100_0;
    localparam logic [10:0] EXP_55 = 11'b0_1_01010101_0;
`endif
    localparam int FRAME = NB * C;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] tx_input;
    logic       new_data;
    logic       tx_wire;
    logic       ready;

    int n_tests;
    int n_fail;

    uart_tx #(
        .DATA_BITS (8),
        .BAUD      (1000000),
        .SYS_CLK   (16000000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .tx_input (tx_input),
        .new_data (new_data),
        .tx_wire  (tx_wire),
        .ready    (ready)
    );

    // Clock and reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait (bounded) for the accepting edge.
    task automatic start_frame(input logic [7:0] data, input bit hold);
        tx_input = data;
        new_data = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (ready === 1'b1) begin
                break;
            end
            step();
        end
        step();
        if (!hold) begin
            new_data = 1'b0;
        end
    endtask

    // Called just after the accepting edge (sample index 0). Records the
    // line at each bit midpoint and counts clocks until ready returns.
    task automatic capture_frame(output logic [10:0] bits, output int low_cycles,
                                 output logic first_line);
        bits       = '0;
        low_cycles = -1;
        first_line = tx_wire;
        for (int i = 0; i < FRAME + 40; i++) begin
            for (int j = 0; j < NB; j++) begin
                if (i == 1 + j * C + C / 2) begin
                    bits[j] = tx_wire;
                end
            end
            if (ready === 1'b1) begin
                low_cycles = i;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        enable   = 1'b1;
        new_data = 1'b0;
        tx_input = 8'h00;
        repeat (3) step();
        n_tests++;
        if (tx_wire !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx_wire: got %b expected 1", tx_wire);
        end
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle();
        int bad_tx;
        int bad_rdy;
        bad_tx  = 0;
        bad_rdy = 0;
        for (int k = 0; k < 200; k++) begin
            if (tx_wire !== 1'b1) bad_tx++;
            if (ready !== 1'b1) bad_rdy++;
            step();
        end
        n_tests++;
        if (bad_tx != 0) begin
            n_fail++;
            $display("FAIL idle_line: %0d cycles not high, expected 0", bad_tx);
        end
        n_tests++;
        if (bad_rdy != 0) begin
            n_fail++;
            $display("FAIL idle_ready: %0d cycles not ready, expected 0", bad_rdy);
        end
    endtask

    task automatic test_send_zero();
        logic [10:0] bits;
        int          low;
        logic        first;
        start_frame(8'h00, 1'b0);
        capture_frame(bits, low, first);
        n_tests++;
        if (first !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_no_early_fall: got %b expected 1", first);
        end
        n_tests++;
        if (bits !== EXP_00) begin
            n_fail++;
            $display("FAIL zero_bits: got %b expected %b", bits, EXP_00);
        end
        n_tests++;
        if (low != FRAME) begin
            n_fail++;
            $display("FAIL zero_ready_low: got %0d expected %0d", low, FRAME);
        end
    endtask

    task automatic test_send_a5();
        logic [10:0] bits;
        int          low;
        logic        first;
        start_frame(8'hA5, 1'b0);
        tx_input = 8'h5A;
        capture_frame(bits, low, first);
        n_tests++;
        if (bits !== EXP_A5) begin
            n_fail++;
            $display("FAIL a5_bits: got %b expected %b", bits, EXP_A5);
        end
        n_tests++;
        if (low != FRAME) begin
            n_fail++;
            $display("FAIL a5_ready_low: got %0d expected %0d", low, FRAME);
        end
    endtask

    task automatic test_odd_ones();
        logic [10:0] bits;
        int          low;
        logic        first;
        start_frame(8'h07, 1'b0);
        capture_frame(bits, low, first);
        n_tests++;
        if (bits !== EXP_07) begin
            n_fail++;
            $display("FAIL x07_bits: got %b expected %b", bits, EXP_07);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits1;
        logic [10:0] bits2;
        int          low1;
        int          low2;
        logic        first1;
        logic        first2;
        start_frame(8'h81, 1'b1);
        tx_input = 8'hBE;
        capture_frame(bits1, low1, first1);
        // new_data is still high: the second word goes on the next edge.
        step();
        new_data = 1'b0;
        tx_input = 8'h00;
        capture_frame(bits2, low2, first2);
        n_tests++;
        if (bits1 !== EXP_81) begin
            n_fail++;
            $display("FAIL b2b_first_bits: got %b expected %b", bits1, EXP_81);
        end
        n_tests++;
        if (low1 != FRAME) begin
            n_fail++;
            $display("FAIL b2b_first_len: got %0d expected %0d", low1, FRAME);
        end
        n_tests++;
        if (bits2 !== EXP_BE) begin
            n_fail++;
            $display("FAIL b2b_second_bits: got %b expected %b", bits2, EXP_BE);
        end
        n_tests++;
        if (low2 != FRAME) begin
            n_fail++;
            $display("FAIL b2b_second_len: got %0d expected %0d", low2, FRAME);
        end
    endtask

    task automatic test_request_ignored_when_busy();
        logic [10:0] bits;
        int          low;
        logic        first;
        int          bad;
        start_frame(8'h3C, 1'b0);
        fork
            capture_frame(bits, low, first);
            begin
                repeat (5) @(posedge clk);
                #2;
                tx_input = 8'bxxxxxxxx;
                new_data = 1'b1;
                repeat (40) @(posedge clk);
                #2;
                new_data = 1'b0;
                tx_input = 8'h00;
            end
        join
        n_tests++;
        if (bits !== EXP_3C) begin
            n_fail++;
            $display("FAIL busy_req_bits: got %b expected %b", bits, EXP_3C);
        end
        n_tests++;
        if (low != FRAME) begin
            n_fail++;
            $display("FAIL busy_req_len: got %0d expected %0d", low, FRAME);
        end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (tx_wire !== 1'b1 || ready !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_req_no_frame: %0d non-idle cycles, expected 0", bad);
        end
    endtask

    task automatic test_enable_drop();
        logic [10:0] bits;
        int          low;
        logic        first;
        int          bad;
        // Abort a zero frame mid-DATA where the line is low.
        start_frame(8'h00, 1'b0);
        repeat (1 + 2 * C + 4) step();
        n_tests++;
        if (tx_wire !== 1'b0) begin
            n_fail++;
            $display("FAIL en_pre_drop_line: got %b expected 0", tx_wire);
        end
        enable = 1'b0;
        step();
        n_tests++;
        if (tx_wire !== 1'b1) begin
            n_fail++;
            $display("FAIL en_drop_line: got %b expected 1", tx_wire);
        end
        // Requests while disabled must not start a frame.
        new_data = 1'b1;
        tx_input = 8'h00;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tx_wire !== 1'b1 || ready !== 1'b0) bad++;
        end
        new_data = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_low_ignored: %0d bad cycles, expected 0", bad);
        end
        enable = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL en_rise_ready: got %b expected 1", ready);
        end
        step();
        // Abort an all-ones frame mid-DATA.
        start_frame(8'hFF, 1'b0);
        repeat (1 + 3 * C + 2) step();
        enable = 1'b0;
        step();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (tx_wire !== 1'b1 || ready !== 1'b0) bad++;
            step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_ff_abort: %0d bad cycles, expected 0", bad);
        end
        enable = 1'b1;
        step();
        // A fresh frame after an abort must start from bit 0.
        start_frame(8'hA5, 1'b0);
        capture_frame(bits, low, first);
        n_tests++;
        if (bits !== EXP_A5) begin
            n_fail++;
            $display("FAIL en_after_abort_bits: got %b expected %b", bits, EXP_A5);
        end
        n_tests++;
        if (low != FRAME) begin
            n_fail++;
            $display("FAIL en_after_abort_len: got %0d expected %0d", low, FRAME);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        int          low;
        logic        first;
        // Reset while data bit 1 (a zero) is on the line.
        start_frame(8'h55, 1'b0);
        repeat (1 + 2 * C + C / 2) step();
        n_tests++;
        if (tx_wire !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre_line: got %b expected 0", tx_wire);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (tx_wire !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async_line: got %b expected 1", tx_wire);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        // Reset during the stop bit.
        start_frame(8'h55, 1'b0);
        repeat (1 + (NB - 1) * C + C / 2) step();
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stop_busy: got %b expected 0", ready);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (tx_wire !== 1'b1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stop_async: got line %b ready %b expected 1 1", tx_wire, ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        start_frame(8'h55, 1'b0);
        capture_frame(bits, low, first);
        n_tests++;
        if (bits !== EXP_55) begin
            n_fail++;
            $display("FAIL rst_after_bits: got %b expected %b", bits, EXP_55);
        end
        n_tests++;
        if (low != FRAME) begin
            n_fail++;
            $display("FAIL rst_after_len: got %0d expected %0d", low, FRAME);
        end
    endtask

    // Sequence and final report
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        new_data = 1'b0;
        tx_input = 8'h00;
        test_reset();
        test_idle();
        test_send_zero();
        test_send_a5();
        test_odd_ones();
        test_back_to_back();
        test_request_ignored_when_busy();
        test_enable_drop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
